// File: rtl/fpcvt_pkg.sv
// Shared definitions for the fpcvt linear-to-float converter pipeline.
// Field widths, saturation limits and the {exp, sig} record used by rounder and packer.
package fpcvt_pkg;

    localparam int unsigned EXP_W_DEF = 3;
    localparam int unsigned SIG_W_DEF = 4;

    localparam logic [EXP_W_DEF-1:0] EMAX = '1;
    localparam logic [SIG_W_DEF-1:0] SMAX = '1;

    typedef struct packed {
        logic [EXP_W_DEF-1:0] exp;
        logic [SIG_W_DEF-1:0] sig;
    } fp_fields_t;

    typedef enum logic [1:0] {
        RND_NONE,
        RND_INC,
        RND_RENORM,
        RND_SAT
    } rnd_case_e;

endpackage

// File: rtl/fp_round_core.sv
// Combinational round-half-up of a truncated {exp, sig} pair.
// Carry out of the widened adds picks renormalize or saturate; nothing ever wraps.
module fp_round_core
    import fpcvt_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic [EXP_W-1:0] exp_in,
    input  logic [SIG_W-1:0] sig_in,
    input  logic             fifth_bit,
    output logic [EXP_W-1:0] exp_out,
    output logic [SIG_W-1:0] sig_out,
    output logic             round_up,
    output logic             saturated
);

    logic [SIG_W:0] sig_sum;
    logic [EXP_W:0] exp_sum;
    rnd_case_e      rnd_case;

    assign sig_sum = {1'b0, sig_in} + {{SIG_W{1'b0}}, 1'b1};
    assign exp_sum = {1'b0, exp_in} + {{EXP_W{1'b0}}, 1'b1};

    always_comb begin
        rnd_case = RND_NONE;
        if (fifth_bit) begin
            if (!sig_sum[SIG_W]) begin
                rnd_case = RND_INC;
            end else if (!exp_sum[EXP_W]) begin
                rnd_case = RND_RENORM;
            end else begin
                rnd_case = RND_SAT;
            end
        end
    end

    always_comb begin
        exp_out   = exp_in;
        sig_out   = sig_in;
        round_up  = 1'b0;
        saturated = 1'b0;
        unique case (rnd_case)
            RND_NONE: ;
            RND_INC: begin
                sig_out  = sig_sum[SIG_W-1:0];
                round_up = 1'b1;
            end
            // Significand carried out: leading 1 moves up one exponent step.
            RND_RENORM: begin
                exp_out  = exp_sum[EXP_W-1:0];
                sig_out  = {1'b1, {(SIG_W-1){1'b0}}};
                round_up = 1'b1;
            end
            RND_SAT: begin
                exp_out   = '1;
                sig_out   = '1;
                saturated = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fp_rounder.sv
// Registered rounding stage: one-cycle latency, valid-qualified, outputs hold when idle.
// Sits between the leading-zero/extract stage and the output packer.
module fp_rounder
    import fpcvt_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned SIG_W = SIG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [SIG_W-1:0] sig_in,
    input  logic             fifth_bit,
    output logic             out_valid,
    output logic [EXP_W-1:0] exp_out,
    output logic [SIG_W-1:0] sig_out,
    output logic             round_up,
    output logic             saturated
);

    logic [EXP_W-1:0] exp_d,   exp_q;
    logic [SIG_W-1:0] sig_d,   sig_q;
    logic             rup_d,   rup_q;
    logic             sat_d,   sat_q;
    logic             valid_q;

    fp_round_core #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W)
    ) u_core (
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .fifth_bit (fifth_bit),
        .exp_out   (exp_d),
        .sig_out   (sig_d),
        .round_up  (rup_d),
        .saturated (sat_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            exp_q   <= '0;
            sig_q   <= '0;
            rup_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                exp_q <= exp_d;
                sig_q <= sig_d;
                rup_q <= rup_d;
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign exp_out   = exp_q;
    assign sig_out   = sig_q;
    assign round_up  = rup_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_fp_rounder.sv
// Self-checking bench for fp_rounder: directed cases, streaming, exhaustive and random
// stimulus compared against an arithmetic round-half-up model.
module tb_fp_rounder;

    localparam int EW = 3;
    localparam int SW = 4;
    localparam int OW = EW + SW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [EW-1:0] exp_in = '0;
    logic [SW-1:0] sig_in = '0;
    logic          fifth_bit = 1'b0;
    logic          out_valid;
    logic [EW-1:0] exp_out;
    logic [SW-1:0] sig_out;
    logic          round_up;
    logic          saturated;

    int errors = 0;
    int checks = 0;

    logic [OW-2:0] held = '0;

    fp_rounder #(
        .EXP_W (EW),
        .SIG_W (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .fifth_bit (fifth_bit),
        .out_valid (out_valid),
        .exp_out   (exp_out),
        .sig_out   (sig_out),
        .round_up  (round_up),
        .saturated (saturated)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {out_valid, exp_out, sig_out, round_up, saturated};

    // Value-level model: add the round bit, halve on overflow, clamp past the top exponent.
    function automatic logic [OW-2:0] ref_round(input int e, input int s, input int f);
        int r;
        int ex;
        logic ru;
        logic sat;
        r   = s + f;
        ex  = e;
        ru  = (f != 0);
        sat = 1'b0;
        if (r >= (1 << SW)) begin
            r  = r / 2;
            ex = ex + 1;
        end
        if (ex > (1 << EW) - 1) begin
            ex  = (1 << EW) - 1;
            r   = (1 << SW) - 1;
            ru  = 1'b0;
            sat = 1'b1;
        end
        return {ex[EW-1:0], r[SW-1:0], ru, sat};
    endfunction

    task automatic drive(input int e, input int s, input int f, input logic v);
        @(negedge clk);
        exp_in    = e[EW-1:0];
        sig_in    = s[SW-1:0];
        fifth_bit = f[0];
        in_valid  = v;
    endtask

    task automatic test_reset;
        logic [OW-1:0] exp_v;
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_init: got %b want %b", obs, {OW{1'b0}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(7, 15, 1, 1'b1);
        @(posedge clk); #1;
        exp_v = {1'b1, 3'b111, 4'b1111, 1'b0, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_preload: got %b want %b", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs, {OW{1'b0}});
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_discard: got %b want %b", obs, {OW{1'b0}});
        end
        @(negedge clk);
        rst_n     = 1'b1;
        exp_in    = 3'b010;
        sig_in    = 4'b1011;
        fifth_bit = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        exp_v = {1'b1, 3'b010, 4'b1011, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_first_edge: got %b want %b", obs, exp_v);
        end
        held = exp_v[OW-2:0];
    endtask

    task automatic test_directed;
        logic [EW-1:0] e_t [4] = '{3'b010, 3'b011, 3'b100, 3'b111};
        logic [SW-1:0] s_t [4] = '{4'b1011, 4'b1010, 4'b1111, 4'b1111};
        logic          f_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [OW-1:0] x_t [4] = '{
            {1'b1, 3'b010, 4'b1011, 1'b0, 1'b0},
            {1'b1, 3'b011, 4'b1011, 1'b1, 1'b0},
            {1'b1, 3'b101, 4'b1000, 1'b1, 1'b0},
            {1'b1, 3'b111, 4'b1111, 1'b0, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            drive(int'(e_t[i]), int'(s_t[i]), int'(f_t[i]), 1'b1);
            @(posedge clk); #1;
            checks++;
            if (obs !== x_t[i]) begin
                errors++;
                $display("FAIL directed_%0d: got %b want %b", i, obs, x_t[i]);
            end
        end
        held = x_t[3][OW-2:0];
    endtask

    task automatic test_back_to_back;
        logic [OW-2:0] q [$];
        logic [OW-1:0] exp_v;
        int e, s, f;
        for (int i = 0; i < 4; i++) begin
            e = $urandom_range(0, (1 << EW) - 1);
            s = $urandom_range(0, (1 << SW) - 1);
            f = $urandom_range(0, 1);
            q.push_back(ref_round(e, s, f));
            drive(e, s, f, 1'b1);
            @(posedge clk); #1;
            held  = q.pop_front();
            exp_v = {1'b1, held};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stream_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 15), 1, 1'b0);
            @(posedge clk); #1;
            exp_v = {1'b0, held};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL stream_idle_%0d: got %b want %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [OW-1:0] exp_v;
        int e, s, f;
        for (int k = 0; k < (1 << (EW + SW + 1)); k++) begin
            e = k >> (SW + 1);
            s = (k >> 1) & ((1 << SW) - 1);
            f = k & 1;
            drive(e, s, f, 1'b1);
            @(posedge clk); #1;
            held  = ref_round(e, s, f);
            exp_v = {1'b1, held};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL exhaustive e=%0d s=%0d f=%0d: got %b want %b", e, s, f, obs, exp_v);
            end
        end
    endtask

    task automatic test_random_valid;
        logic [OW-1:0] exp_v;
        logic v;
        int e, s, f;
        for (int i = 0; i < 300; i++) begin
            e = $urandom_range(0, (1 << EW) - 1);
            s = $urandom_range(0, (1 << SW) - 1);
            f = $urandom_range(0, 1);
            v = 1'($urandom_range(0, 1));
            drive(e, s, f, v);
            @(posedge clk); #1;
            if (v) held = ref_round(e, s, f);
            exp_v = {v, held};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_%0d v=%0d e=%0d s=%0d f=%0d: got %b want %b",
                         i, v, e, s, f, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_exhaustive();
        test_random_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_rounder.md
Name: fp_rounder

Overview:
Rounding stage of the fpcvt linear-to-float converter: takes a truncated exponent/significand pair plus the first discarded bit and rounds half-up.
- Handles significand overflow by renormalizing into the exponent.
- Saturates at the largest representable magnitude.
- Sits between the leading-zero/extract stage and the output packer.
- Registered, one-cycle latency, with a valid qualifier.

Parameters:
EXP_W, 3, exponent field width in bits
SIG_W, 4, significand field width in bits

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input fields are valid this cycle
exp_in  input  EXP_W  unrounded exponent
sig_in  input  SIG_W  unrounded significand (MSB is the leading 1 for normalized values)
fifth_bit  input  1  first bit below the significand LSB (round bit)
out_valid  output  1  output fields are valid
exp_out  output  EXP_W  rounded exponent
sig_out  output  SIG_W  rounded significand
round_up  output  1  rounding incremented the value
saturated  output  1  result was clamped to max magnitude

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, independent of clk): out_valid=0, exp_out=0, sig_out=0, round_up=0, saturated=0. Deassertion takes effect at the next rising edge.
- Latency: exactly 1 cycle. Inputs sampled at a rising edge with in_valid=1 appear on the outputs after that edge, with out_valid=1.
- No backpressure. A new input is accepted every cycle.
- in_valid=0 at an edge: out_valid<=0, and the data outputs and flags hold their previous values.
- Rounding rules, evaluated combinationally, with EMAX = all ones (EXP_W) and SMAX = all ones (SIG_W):
  - fifth_bit=0: exp_out=exp_in, sig_out=sig_in, round_up=0, saturated=0.
  - fifth_bit=1, sig_in!=SMAX: sig_out=sig_in+1, exp_out=exp_in, round_up=1.
  - fifth_bit=1, sig_in=SMAX, exp_in!=EMAX: sig_out=1 followed by SIG_W-1 zeros (0b1000 at default), exp_out=exp_in+1, round_up=1.
  - fifth_bit=1, sig_in=SMAX, exp_in=EMAX: exp_out=EMAX, sig_out=SMAX, round_up=0, saturated=1.
- No arithmetic wrap of the exponent is ever visible. All adds are computed SIG_W+1 / EXP_W+1 bits wide, and the carry out selects the renormalize or saturate branch.
- The significand is unsigned. No sign handling in this block; the sign bit bypasses it.
- Reset asserted mid-stream: outputs clear immediately, and the in-flight result is discarded.
- in_valid=1 on the first edge after reset release: the result is registered normally.

Decomposition:
- Shared package fpcvt_pkg holds:
  - the EXP_W/SIG_W default constants;
  - EMAX/SMAX localparams derived from them;
  - a struct typedef for the {exp, sig} float fields, reused by the packer.
- One combinational sub-module, fp_round_core: exp_in, sig_in, fifth_bit -> exp, sig, round_up, saturated.
- fp_rounder wraps fp_round_core with the valid/output registers and reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 immediately without a clock edge; out_valid=0.
- No round: exp_in=010, sig_in=1011, fifth_bit=0, in_valid=1 -> next cycle exp_out=010, sig_out=1011, round_up=0, saturated=0, out_valid=1.
- Simple round: exp_in=011, sig_in=1010, fifth_bit=1 -> exp_out=011, sig_out=1011, round_up=1.
- Renormalize: exp_in=100, sig_in=1111, fifth_bit=1 -> exp_out=101, sig_out=1000, round_up=1, saturated=0.
- Saturate: exp_in=111, sig_in=1111, fifth_bit=1 -> exp_out=111, sig_out=1111, saturated=1, round_up=0.
- Streaming/valid: back-to-back valid inputs for 4 cycles, then in_valid=0 -> results appear one per cycle in order; out_valid drops one cycle after in_valid drops; data holds the last value.
- Exhaustive: all 2^(EXP_W+SIG_W+1) combinations against a reference model -> zero mismatches.
